smem_store_arbiter: RTL and testbench

//  Merges the two write streams of backward-extension stage 1 (store_valid_mem / store_valid_curr) and
//  the downstream read port onto one single-port buffer RAM. Each write stream has its own small FIFO.

---
 rtl/smem_store_arbiter.sv | 148 ++++++++++++++
 tb/tb_smem_store_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smem_store_arbiter.sv
// Shares one single-port buffer RAM between two buffered write streams (mem, curr) and a downstream reader.
// Each write stream is queued in a small FIFO, and a full FIFO raises stall back to the pipeline.
module smem_store_arbiter #(
    parameter int DEPTH  = 4,
    parameter int PW     = 256,
    parameter int RNW    = 6,
    parameter int AW     = 7,
    parameter int STARVE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic [PW-1:0]        mem_data,
    input  logic [AW-1:0]        mem_addr,
    input  logic [RNW-1:0]       mem_read,
    input  logic                 curr_valid,
    input  logic [PW-1:0]        curr_data,
    input  logic [AW-1:0]        curr_addr,
    input  logic [RNW-1:0]       curr_read,
    output logic                 stall,
    input  logic                 rd_req,
    input  logic [RNW+AW:0]      rd_addr,
    output logic                 rd_grant,
    output logic                 rd_valid,
    output logic [PW-1:0]        rd_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [RNW+AW:0]      ram_addr,
    output logic [PW-1:0]        ram_wdata,
    input  logic [PW-1:0]        ram_rdata
);
    localparam int RAW  = 1 + RNW + AW;
    localparam int EW   = RAW + PW;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PTRW + 1;
    localparam int SW   = $clog2(STARVE + 1);

    logic [1:0]          in_valid;
    logic [1:0][EW-1:0]  in_entry;
    logic [1:0][EW-1:0]  head;
    logic [1:0]          full;
    logic [1:0]          nonempty;
    logic [1:0]          push;
    logic [1:0]          pop;

    logic                rr_ptr_reg;
    logic [SW-1:0]       starve_cnt_reg;
    logic                rd_valid_reg;
    logic [PW-1:0]       rd_hold_reg;

    logic                rd_grant_next;
    logic                wr_grant_next;
    logic                wr_sel_next;
    logic [EW-1:0]       sel_head;

    assign in_valid    = {curr_valid, mem_valid};
    assign in_entry[0] = {1'b0, mem_read, mem_addr, mem_data};
    assign in_entry[1] = {1'b1, curr_read, curr_addr, curr_data};
    assign stall       = |full;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [EW-1:0]   store [DEPTH];
            logic [PTRW-1:0] wr_ptr_reg;
            logic [PTRW-1:0] rd_ptr_reg;
            logic [CW-1:0]   cnt_reg;

            assign full[gi]     = (cnt_reg == CW'(DEPTH));
            assign nonempty[gi] = (cnt_reg != '0);
            assign push[gi]     = in_valid[gi] & ~stall;
            assign head[gi]     = store[rd_ptr_reg];

            // Storage carries no reset so it can map onto distributed RAM.
            always_ff @(posedge clk) begin
                if (push[gi])
                    store[wr_ptr_reg] <= in_entry[gi];
            end

            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push[gi])
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (push[gi] && !pop[gi])
                        cnt_reg <= cnt_reg + 1'b1;
                    else if (!push[gi] && pop[gi])
                        cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    endgenerate

    // Grants are masked by reset so the port is quiet the moment reset is asserted.
    always_comb begin
        rd_grant_next = 1'b0;
        wr_grant_next = 1'b0;
        wr_sel_next   = 1'b0;
        if (rst) begin
            if (stall && (starve_cnt_reg >= SW'(STARVE))) begin
                wr_grant_next = 1'b1;
                wr_sel_next   = (&full) ? rr_ptr_reg : full[1];
            end else if (rd_req) begin
                rd_grant_next = 1'b1;
            end else if (|nonempty) begin
                wr_grant_next = 1'b1;
                wr_sel_next   = (&nonempty) ? rr_ptr_reg : nonempty[1];
            end
        end
    end

    assign pop       = {wr_grant_next & wr_sel_next, wr_grant_next & ~wr_sel_next};
    assign sel_head  = head[wr_sel_next];
    assign rd_grant  = rd_grant_next;
    assign ram_en    = rd_grant_next | wr_grant_next;
    assign ram_we    = wr_grant_next;
    assign ram_addr  = rd_grant_next ? rd_addr : (wr_grant_next ? sel_head[EW-1:PW] : '0);
    assign ram_wdata = wr_grant_next ? sel_head[PW-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg     <= 1'b0;
            starve_cnt_reg <= '0;
            rd_valid_reg   <= 1'b0;
            rd_hold_reg    <= '0;
        end else begin
            if (wr_grant_next)
                rr_ptr_reg <= ~wr_sel_next;
            if (wr_grant_next || !stall)
                starve_cnt_reg <= '0;
            else if (rd_grant_next && (starve_cnt_reg < SW'(STARVE)))
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            rd_valid_reg <= rd_grant_next;
            if (rd_valid_reg)
                rd_hold_reg <= ram_rdata;
        end
    end

    // Read data is presented in the rd_valid cycle and held afterwards.
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_valid_reg ? ram_rdata : rd_hold_reg;

endmodule

// File: tb/tb_smem_store_arbiter.sv
// Directed self-checking bench for smem_store_arbiter: one task per scenario, inline comparisons.
// A second instance built with DEPTH=2 exercises pointer wrap.
module tb_smem_store_arbiter;
    localparam int PW  = 256;
    localparam int RNW = 6;
    localparam int AW  = 7;
    localparam int RAW = 1 + RNW + AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_valid = 1'b0, curr_valid = 1'b0, rd_req = 1'b0;
    logic [PW-1:0]  mem_data = '0, curr_data = '0;
    logic [AW-1:0]  mem_addr = '0, curr_addr = '0;
    logic [RNW-1:0] mem_read = '0, curr_read = '0;
    logic [RAW-1:0] rd_addr = '0;
    logic stall, rd_grant, rd_valid, ram_en, ram_we;
    logic [PW-1:0]  rd_data, ram_wdata;
    logic [PW-1:0]  ram_rdata = '0;
    logic [RAW-1:0] ram_addr;

    logic d2_mem_valid = 1'b0, d2_rd_req = 1'b0;
    logic [PW-1:0]  d2_mem_data = '0;
    logic [PW-1:0]  d2_zero_data = '0;
    logic [AW-1:0]  d2_zero_addr = '0;
    logic [RNW-1:0] d2_zero_read = '0;
    logic [RAW-1:0] d2_rd_addr = '0;
    logic d2_curr_valid = 1'b0;
    logic d2_stall, d2_rd_grant, d2_rd_valid, d2_ram_en, d2_ram_we;
    logic [PW-1:0]  d2_rd_data, d2_ram_wdata;
    logic [PW-1:0]  d2_ram_rdata = '0;
    logic [RAW-1:0] d2_ram_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    smem_store_arbiter #(.DEPTH(4), .PW(PW), .RNW(RNW), .AW(AW), .STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_addr(mem_addr), .mem_read(mem_read),
        .curr_valid(curr_valid), .curr_data(curr_data), .curr_addr(curr_addr), .curr_read(curr_read),
        .stall(stall), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    smem_store_arbiter #(.DEPTH(2), .PW(PW), .RNW(RNW), .AW(AW), .STARVE(4)) dut2 (
        .clk(clk), .rst(rst),
        .mem_valid(d2_mem_valid), .mem_data(d2_mem_data), .mem_addr(d2_zero_addr), .mem_read(d2_zero_read),
        .curr_valid(d2_curr_valid), .curr_data(d2_zero_data), .curr_addr(d2_zero_addr), .curr_read(d2_zero_read),
        .stall(d2_stall), .rd_req(d2_rd_req), .rd_addr(d2_rd_addr), .rd_grant(d2_rd_grant),
        .rd_valid(d2_rd_valid), .rd_data(d2_rd_data),
        .ram_en(d2_ram_en), .ram_we(d2_ram_we), .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata),
        .ram_rdata(d2_ram_rdata)
    );

    function automatic logic [PW-1:0] pat(input logic [RAW-1:0] a);
        return {192'h0, 50'h3_1415_9265_3589, a};
    endfunction

    function automatic logic [PW-1:0] mk(input int s, input int k);
        return {32'hFEED_0000 + 32'(s), 32'(k), 192'h5A5A};
    endfunction

    // Latency-1 RAM model: a read registers a known address-derived pattern.
    always @(posedge clk) begin
        if (ram_en && !ram_we)
            ram_rdata <= pat(ram_addr);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid = 0; curr_valid = 0; rd_req = 0;
        mem_data = '0; curr_data = '0; mem_addr = '0; curr_addr = '0;
        mem_read = '0; curr_read = '0; rd_addr = '0;
        d2_mem_valid = 0; d2_rd_req = 0; d2_mem_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        mem_valid = 1; curr_valid = 1; rd_req = 1; rd_addr = 14'h1234;
        #2;
        tests++;
        if ({stall, rd_grant, rd_valid, ram_en, ram_we} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0 || rd_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h, want all zero",
                     {stall, rd_grant, rd_valid, ram_en, ram_we}, ram_addr);
        end
        do_reset();
        @(negedge clk);
        tests++;
        if ({stall, ram_en} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: got stall/ram_en=%b, want 00", {stall, ram_en});
        end
        next();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_push();
        do_reset();
        mem_valid = 1; mem_addr = 7'd3; mem_read = 6'd5; mem_data = mk(1, 1);
        @(negedge clk);
        tests++;
        if (ram_en !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL single_no_bypass: got ram_en=%b stall=%b, want 0 0", ram_en, stall);
        end
        next();
        mem_valid = 0;
        @(negedge clk);
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== {1'b0, 6'd5, 7'd3} || ram_wdata !== mk(1, 1) || stall !== 1'b0) begin
            fails++;
            $display("FAIL single_write: got we=%b addr=%h stall=%b, want 1 %h 0",
                     ram_we, ram_addr, stall, {1'b0, 6'd5, 7'd3});
        end
        next();
        @(negedge clk);
        tests++;
        if (ram_en !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got ram_en=%b, want 0", ram_en);
        end
        next();
        $display("[TB] test_single_push done");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            mem_valid  = (k < 6);
            curr_valid = (k < 6);
            mem_data   = mk(2, k);     mem_addr  = 7'(k);     mem_read  = 6'(k + 1);
            curr_data  = mk(3, k);     curr_addr = 7'(k + 8); curr_read = 6'(k + 2);
            @(negedge clk);
            if (k < 6) begin
                tests++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL rr_stall cycle %0d: got stall=%b, want 0", k, stall);
                end
            end
            if (k >= 1) begin
                int j = k - 1;
                int idx = j / 2;
                logic [RAW-1:0] ea;
                logic [PW-1:0]  ed;
                if (j % 2 == 0) begin
                    ea = {1'b0, 6'(idx + 1), 7'(idx)};
                    ed = mk(2, idx);
                end else begin
                    ea = {1'b1, 6'(idx + 2), 7'(idx + 8)};
                    ed = mk(3, idx);
                end
                tests++;
                if (ram_we !== 1'b1 || ram_addr !== ea || ram_wdata !== ed) begin
                    fails++;
                    $display("FAIL rr_write %0d: got we=%b addr=%h, want 1 %h", j, ram_we, ram_addr, ea);
                end
            end
            next();
        end
        clear_inputs();
        @(negedge clk);
        tests++;
        if (ram_en !== 1'b0) begin
            fails++;
            $display("FAIL rr_drained: got ram_en=%b, want 0", ram_en);
        end
        next();
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_starve();
        logic [RAW-1:0] ra;
        do_reset();
        ra = {1'b1, 6'd63, 7'd77};
        rd_req = 1; rd_addr = ra;
        for (int k = 0; k <= 10; k++) begin
            int idx = (k < 4) ? k : 4;
            logic exp_stall, exp_grant, exp_valid;
            mem_valid = (k <= 9);
            mem_data = mk(4, idx); mem_addr = 7'(idx + 20); mem_read = 6'd2;
            exp_stall = ((k >= 4) && (k <= 8)) || (k == 10);
            exp_grant = (k != 8);
            exp_valid = (k >= 1) && (k != 9);
            @(negedge clk);
            tests++;
            if (stall !== exp_stall || rd_grant !== exp_grant || rd_valid !== exp_valid) begin
                fails++;
                $display("FAIL starve cycle %0d: got stall/grant/valid=%b%b%b, want %b%b%b",
                         k, stall, rd_grant, rd_valid, exp_stall, exp_grant, exp_valid);
            end
            if (k == 0) begin
                tests++;
                if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ra) begin
                    fails++;
                    $display("FAIL starve_read_port: got en=%b we=%b addr=%h, want 1 0 %h", ram_en, ram_we, ram_addr, ra);
                end
            end
            if (k == 1) begin
                tests++;
                if (rd_data !== pat(ra)) begin
                    fails++;
                    $display("FAIL starve_rd_data: got %h, want %h", rd_data[63:0], pat(ra));
                end
            end
            if (k == 8) begin
                tests++;
                if (ram_we !== 1'b1 || ram_addr !== {1'b0, 6'd2, 7'd20} || ram_wdata !== mk(4, 0)) begin
                    fails++;
                    $display("FAIL starve_override: got we=%b addr=%h, want 1 %h", ram_we, ram_addr, {1'b0, 6'd2, 7'd20});
                end
            end
            if (k == 9) begin
                tests++;
                if (rd_data !== pat(ra)) begin
                    fails++;
                    $display("FAIL starve_rd_hold: got %h, want %h", rd_data[63:0], pat(ra));
                end
            end
            next();
        end
        clear_inputs();
        $display("[TB] test_starve done");
    endtask

    task automatic test_stall_hold();
        int mem_writes;
        do_reset();
        mem_writes = 0;
        rd_addr = {1'b0, 6'd9, 7'd9};
        for (int k = 0; k <= 11; k++) begin
            rd_req     = (k < 6);
            curr_valid = (k < 4);
            curr_data  = mk(5, k); curr_addr = 7'(k + 40); curr_read = 6'd7;
            mem_valid  = (k >= 4) && (k <= 7);
            mem_data   = mk(6, 99); mem_addr = 7'd11; mem_read = 6'd12;
            @(negedge clk);
            if (k >= 4 && k <= 7) begin
                tests++;
                if (stall !== (k <= 6)) begin
                    fails++;
                    $display("FAIL hold_stall cycle %0d: got %b, want %b", k, stall, (k <= 6));
                end
            end
            if (ram_we === 1'b1 && ram_addr[RAW-1] === 1'b0)
                mem_writes++;
            if (k == 8) begin
                tests++;
                if (ram_we !== 1'b1 || ram_addr !== {1'b0, 6'd12, 7'd11} || ram_wdata !== mk(6, 99)) begin
                    fails++;
                    $display("FAIL hold_write: got we=%b addr=%h, want 1 %h", ram_we, ram_addr, {1'b0, 6'd12, 7'd11});
                end
            end
            next();
        end
        tests++;
        if (mem_writes !== 1) begin
            fails++;
            $display("FAIL hold_once: got %0d mem writes, want 1", mem_writes);
        end
        clear_inputs();
        $display("[TB] test_stall_hold done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rd_req = (k < 4);
            mem_valid = (k < 4);  mem_data = mk(7, k);  mem_addr = 7'(k);  mem_read = 6'd1;
            curr_valid = (k < 4); curr_data = mk(8, k); curr_addr = 7'(k); curr_read = 6'd1;
            if (k == 4) begin
                @(negedge clk);
                tests++;
                if (stall !== 1'b1 || ram_we !== 1'b1) begin
                    fails++;
                    $display("FAIL arst_full: got stall=%b we=%b, want 1 1", stall, ram_we);
                end
            end
            next();
        end
        rst = 0;
        #1;
        tests++;
        if ({stall, rd_grant, rd_valid, ram_en, ram_we} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            fails++;
            $display("FAIL arst_outputs: got ctl=%b addr=%h, want all zero",
                     {stall, rd_grant, rd_valid, ram_en, ram_we}, ram_addr);
        end
        next();
        rst = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (ram_en !== 1'b0 || stall !== 1'b0) begin
                fails++;
                $display("FAIL arst_quiet cycle %0d: got en=%b stall=%b, want 0 0", k, ram_en, stall);
            end
            next();
        end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_wrap_depth2();
        int pidx, widx;
        do_reset();
        pidx = 0;
        widx = 0;
        for (int c = 0; c < 60; c++) begin
            d2_rd_req    = ((c % 5) < 2);
            d2_mem_valid = (pidx < 10);
            d2_mem_data  = mk(9, pidx);
            @(negedge clk);
            if (d2_ram_we === 1'b1) begin
                tests++;
                if (d2_ram_wdata !== mk(9, widx)) begin
                    fails++;
                    $display("FAIL wrap_order %0d: got %h, want %h", widx, d2_ram_wdata[223:192], mk(9, widx) >> 192);
                end
                widx++;
            end
            if (d2_mem_valid && !d2_stall)
                pidx++;
            next();
        end
        tests++;
        if (widx !== 10) begin
            fails++;
            $display("FAIL wrap_count: got %0d writes, want 10", widx);
        end
        clear_inputs();
        $display("[TB] test_wrap_depth2 done");
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_starve();
        test_stall_hold();
        test_async_reset();
        test_wrap_depth2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
